bus_master_ctrl: RTL and testbench

//  Parametrised successor to the single-beat CPU bus controller: sequences single or incrementing-burst

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_beat_timer.sv | 38 +++
 rtl/bus_master_ctrl.sv | 151 +++++++++++++++
 tb/tb_bus_master_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: state encoding and bus direction constants
// shared by the bus master controller files.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  localparam logic BUS_MODE_WR = 1'b1;
  localparam logic BUS_MODE_RD = 1'b0;

endpackage

// File: rtl/bus_beat_timer.sv
// bus_beat_timer: cycles since the last beat or start;
// flags expiry when TO_CYC cycles pass without progress.
module bus_beat_timer #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = run_i && !clr_i &&
                    (cnt_q == CW'(TO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !run_i) begin
      cnt_d = '0;
    end else if (!expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: single/burst read-write sequencer for the CPU bus.
// Define BUS_TIMEOUT_EN to abort a beat stalled for TO_CYC cycles.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned LENW   = 4,
  parameter int unsigned TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_transaction,
  input  logic            mode,
  input  logic [AW-1:0]   addr,
  input  logic [LENW-1:0] len,
  input  logic [DW-1:0]   wdata,
  output logic            beat_ack,
  output logic [DW-1:0]   rdata,
  output logic            rdata_valid,
  output logic            write_done,
  output logic            busy,
  output logic            bus_err,
  output logic [AW-1:0]   BUS_addr,
  output logic [DW-1:0]   BUS_wdata,
  input  logic [DW-1:0]   BUS_rdata,
  output logic            BUS_valid,
  input  logic            BUS_wready,
  output logic            BUS_rready,
  input  logic            BUS_rvalid,
  output logic            BUS_mode
);

  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            mode_q, mode_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvld_q, rvld_d;
  logic            wdone_q, wdone_d;
  logic            err_q, err_d;

  logic wr_beat;
  logic rd_beat;
  logic beat;
  logic last;
  logic timeout;

  assign wr_beat = (state_q == WR) && BUS_wready;
  assign rd_beat = (state_q == RD) && BUS_rvalid;
  assign beat    = wr_beat || rd_beat;
  assign last    = (cnt_q == len_q);

`ifdef BUS_TIMEOUT_EN
  bus_beat_timer #(
    .TO_CYC (TO_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (beat),
    .run_i    (busy),
    .expire_o (timeout)
  );
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    wdone_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_transaction) begin
          state_d = (mode == BUS_MODE_WR) ? WR : RD;
          addr_d  = addr;
          mode_d  = mode;
          len_d   = len;
          cnt_d   = '0;
        end
      end
      WR, RD: begin
        if (beat) begin
          addr_d = addr_q + STEP;
          cnt_d  = cnt_q + 1'b1;
          if (rd_beat) begin
            rdata_d = BUS_rdata;
            rvld_d  = 1'b1;
          end
          if (last) begin
            state_d = IDLE;
            wdone_d = wr_beat;
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      wdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      wdone_q <= wdone_d;
      err_q   <= err_d;
    end
  end

  // write acks are immediate so the core can advance wdata next cycle
  assign beat_ack    = wr_beat || rvld_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
  assign write_done  = wdone_q;
  assign bus_err     = err_q;
  assign busy        = (state_q != IDLE);
  assign BUS_valid   = busy;
  assign BUS_rready  = (state_q == RD);
  assign BUS_mode    = mode_q;
  assign BUS_addr    = addr_q;
  assign BUS_wdata   = (state_q == WR) ? wdata : '0;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb_bus_master_ctrl: random and directed transactions with a
// scoreboard of expected bus beats and read data.
module tb_bus_master_ctrl;

  typedef struct {
    logic [31:0] a;
    logic        m;
    logic [31:0] d;
    bit          last;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } rd_t;

  logic        clk;
  logic        rst_n;
  logic        start_transaction;
  logic        mode;
  logic [31:0] addr;
  logic [3:0]  len;
  logic [31:0] wdata;
  logic        beat_ack;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        write_done;
  logic        busy;
  logic        bus_err;
  logic [31:0] BUS_addr;
  logic [31:0] BUS_wdata;
  logic [31:0] BUS_rdata;
  logic        BUS_valid;
  logic        BUS_wready;
  logic        BUS_rready;
  logic        BUS_rvalid;
  logic        BUS_mode;

  int checks;
  int errors;
  bit mon_en;
  int lat_cfg;

  beat_t       exp_bus[$];
  rd_t         exp_rd[$];
  logic [31:0] wq[$];

  bus_master_ctrl #(
    .AW(32), .DW(32), .LENW(4), .TO_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_transaction(start_transaction),
    .mode(mode), .addr(addr), .len(len), .wdata(wdata),
    .beat_ack(beat_ack), .rdata(rdata),
    .rdata_valid(rdata_valid), .write_done(write_done),
    .busy(busy), .bus_err(bus_err),
    .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata),
    .BUS_rdata(BUS_rdata), .BUS_valid(BUS_valid),
    .BUS_wready(BUS_wready), .BUS_rready(BUS_rready),
    .BUS_rvalid(BUS_rvalid), .BUS_mode(BUS_mode)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // slave: ready after a per-beat latency, data from mem_fn(addr)
  bit rdy;
  int cur_lat;
  int wait_cnt;
  initial begin
    BUS_wready = 0;
    BUS_rvalid = 0;
    BUS_rdata  = 0;
    rdy = 0;
    cur_lat = 0;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (BUS_valid) begin
        rdy = (wait_cnt >= cur_lat);
        BUS_wready = rdy;
        BUS_rvalid = rdy;
        BUS_rdata  = mem_fn(BUS_addr);
      end else begin
        rdy = 0;
        BUS_wready = 1'($urandom);
        BUS_rvalid = 1'($urandom);
        BUS_rdata  = $urandom;
      end
      @(negedge clk);
      if (!BUS_valid || rdy) begin
        wait_cnt = 0;
        cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else begin
        wait_cnt++;
      end
    end
  end

  // core write data: advance to the next beat after each write handshake
  initial begin
    bit hs;
    wdata = 0;
    forever begin
      @(negedge clk);
      hs = BUS_valid && BUS_mode && BUS_wready;
      @(posedge clk); #1;
      if (hs && wq.size() > 0) void'(wq.pop_front());
      wdata = (wq.size() > 0) ? wq[0] : $urandom;
    end
  end

  // scoreboard monitor
  initial begin
    bit wr_hs, rd_hs, rd_prev, wl_prev, wl_now;
    beat_t e;
    rd_t r;
    rd_prev = 0;
    wl_prev = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        rd_prev = 0;
        wl_prev = 0;
      end else begin
        wr_hs = BUS_valid && BUS_mode && BUS_wready;
        rd_hs = BUS_valid && !BUS_mode && BUS_rready && BUS_rvalid;
        if (BUS_valid) chk("rready", BUS_rready, !BUS_mode);
        chk("busy_vs_valid", busy, BUS_valid);
        chk("beat_ack", beat_ack, wr_hs || rd_prev);
        chk("rdata_valid", rdata_valid, rd_prev);
        chk("write_done", write_done, wl_prev);
        chk("bus_err", bus_err, 0);
        wl_now = 0;
        if (wr_hs || rd_hs) begin
          checks++;
          if (exp_bus.size() == 0) begin
            errors++;
            $display("FAIL unexp_beat act=%0h exp=none", BUS_addr);
          end else begin
            e = exp_bus.pop_front();
            chk("beat_addr", BUS_addr, e.a);
            chk("beat_mode", BUS_mode, e.m);
            if (e.m) chk("beat_wdata", BUS_wdata, e.d);
            wl_now = wr_hs && e.last;
          end
        end
        if (rd_prev) begin
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL unexp_rdata act=%0h exp=none", rdata);
          end else begin
            r = exp_rd.pop_front();
            chk("rdata", rdata, r.d);
            if (r.last) chk("rd_end_busy", busy, 0);
          end
        end
        if (wl_prev) chk("wr_end_busy", busy, 0);
        rd_prev = rd_hs;
        wl_prev = wl_now;
      end
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, {beat_ack, rdata_valid, write_done, busy,
                         bus_err, BUS_valid, BUS_rready, BUS_mode}, 0);
    chk({name, "_addr"}, BUS_addr, 0);
    chk({name, "_rdata"}, rdata, 0);
    chk({name, "_wdata"}, BUS_wdata, 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    start_transaction = 0;
    rst_n = 0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    exp_bus.delete();
    exp_rd.delete();
    wq.delete();
    @(negedge clk);
    mon_en = 1;
  endtask

  task automatic set_lat(input int v);
    lat_cfg = v;
    repeat (2) @(negedge clk);
  endtask

  // entered and left at a negedge with the DUT idle
  task automatic do_txn(input logic m, input logic [31:0] a,
                        input logic [3:0] l, input bit noise,
                        input logic [31:0] d0);
    beat_t e;
    rd_t r;
    int n;
    for (int i = 0; i <= int'(l); i++) begin
      e.a = a + 32'(4 * i);
      e.m = m;
      e.d = (i == 0) ? d0 : $urandom;
      e.last = (i == int'(l));
      exp_bus.push_back(e);
      if (m) begin
        wq.push_back(e.d);
      end else begin
        r.d = mem_fn(e.a);
        r.last = e.last;
        exp_rd.push_back(r);
      end
    end
    start_transaction = 1;
    mode = m;
    addr = a;
    len = l;
    @(negedge clk);
    chk("lat_valid", BUS_valid, 1);
    chk("lat_addr", BUS_addr, a);
    chk("lat_mode", BUS_mode, m);
    n = 0;
    while (busy && n < 200) begin
      if (noise) begin
        start_transaction = 1;
        mode = 1'($urandom);
        addr = $urandom;
        len = 4'($urandom);
      end else begin
        start_transaction = 0;
      end
      @(negedge clk);
      n++;
    end
    start_transaction = 0;
    if (busy) begin
      chk("txn_done_in_budget", busy, 0);
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] a;
    int nv;
    checks = 0;
    errors = 0;
    mon_en = 0;
    lat_cfg = 0;
    start_transaction = 0;
    mode = 0;
    addr = 0;
    len = 0;
    rst_n = 0;
    do_reset();

    set_lat(2);
    do_txn(1'b1, 32'h100, 4'd0, 1'b0, 32'hDEAD_BEEF);
    set_lat(0);
    do_txn(1'b0, 32'h200, 4'd3, 1'b0, 32'h0);
    set_lat(-1);
    do_txn(1'b1, 32'hFFFF_FFFC, 4'd1, 1'b0, $urandom);
    set_lat(0);
    do_txn(1'b1, 32'h500, 4'd5, 1'b1, $urandom);
    do_txn(1'b0, 32'h600, 4'd3, 1'b1, $urandom);
    do_txn(1'b1, 32'h700, 4'd15, 1'b1, $urandom);

    // reset during beat 2 of a 4-beat read
    mon_en = 0;
    start_transaction = 1;
    mode = 0;
    addr = 32'h400;
    len = 4'd3;
    @(negedge clk);
    start_transaction = 0;
    repeat (2) @(negedge clk);
    chk("rst_beat2_addr", BUS_addr, 32'h408);
    do_reset();

    // stalled write beat
    set_lat(100000);
    mon_en = 0;
    start_transaction = 1;
    mode = 1;
    addr = 32'h800;
    len = 4'd0;
    @(negedge clk);
    start_transaction = 0;
    nv = 0;
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      if (BUS_valid && !bus_err) nv++;
      @(negedge clk);
    end
    chk("to_valid_cycles", nv, 8);
    chk("to_err", bus_err, 1);
    chk("to_valid_drop", BUS_valid, 0);
    chk("to_idle", busy, 0);
    @(negedge clk);
    chk("to_err_pulse", bus_err, 0);
    mon_en = 1;
`else
    for (int i = 0; i < 120; i++) begin
      if (BUS_valid && !bus_err) nv++;
      @(negedge clk);
    end
    chk("stall_valid_cycles", nv, 120);
    chk("stall_busy", busy, 1);
    do_reset();
`endif

    set_lat(-1);
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + ($urandom % 64)
                                      : $urandom;
      do_txn(1'($urandom), a, 4'($urandom), 1'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("bus_q_empty", exp_bus.size(), 0);
    chk("rd_q_empty", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
